ctrl_pipe_unit: RTL
===================

# ctrl_pipe_unit

Pipelined control unit for the 5-stage MIPS-subset CPU. It decodes the ID-stage opcode into the stage control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also generates the pipeline stall for load-use hazards and for a multi-cycle multiply of parametrised latency, and applies branch flush and an external freeze. The datapath consumes the per-stage outputs directly; `stall` holds the PC and the IF/ID register.

## Interface
- WIDTH_I, 32, instruction width; kept for datapath consistency, no internal use.
- MULT_LAT, 3, cycles a multiply occupies EX; legal range 1..16.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  ID-stage opcode.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs, id_rt  in  5 each  ID-stage source register numbers.
- flush  in  1  branch taken, resolved in MEM; kills the ID and EX instructions.
- ext_stall  in  1  memory freeze; holds all control registers.
- stall  out  1  hold PC and IF/ID.
- illegal  out  1  combinational; id_valid with an undefined opcode.
- ex_valid, ex_rfile_dst, ex_alu_src, ex_mult_sel  out  1 each  EX controls.
- ex_alu_op  out  3  EX ALU operation.
- ex_rt  out  5  EX destination candidate.
- mem_valid, mem_r, mem_w, mem_branch  out  1 each  MEM controls.
- wb_valid, wb_mem_to_rfile, wb_rfile_w  out  1 each  WB controls.

## Operation
- Decode table, in the order rfile_dst, alu_src, mem_to_rfile, rfile_w, mem_r, mem_w, branch, alu_op, mult_sel:
  - 000000 R-type: 1,0,0,1,0,0,0,010,0
  - 001000 addi: 0,1,0,1,0,0,0,110,0
  - 001100 andi: 0,1,0,1,0,0,0,111,0
  - 001101 ori: 0,1,0,1,0,0,0,100,0
  - 100011 lw: 0,1,1,1,1,0,0,000,0
  - 101011 sw: 0,1,0,0,0,1,0,000,0
  - 000100 beq: 0,0,0,0,0,0,1,001,0
  - 011100 mul: 1,0,0,1,0,0,0,111,1
- Any other opcode decodes to all-zero controls and a bubble; `illegal` = id_valid & undefined.
- Bubble: valid = 0 and all control bits 0. A bubble must never assert mem_r, mem_w, branch or rfile_w downstream.
- Load-use hazard (`lu`): ex_valid & mem_r-in-EX & ex_rt≠0 & id_valid & (ex_rt==id_rs | ex_rt==id_rt).
- Multiply sequencer: 4-bit counter `mcnt`, states IDLE/BUSY.
  - When a mul is captured into ID/EX and MULT_LAT>1: load mcnt = MULT_LAT-1 and enter BUSY.
  - In BUSY, each un-frozen cycle decrements mcnt. ID/EX holds; EX/MEM receives a bubble.
  - When mcnt==0, return to IDLE; the mul advances on the next edge.
- Priority per edge: rst > ext_stall > flush > mul BUSY > lu > normal advance.
  - ext_stall: every register and mcnt holds.
  - flush: ID/EX takes a bubble; an in-progress mul is aborted (mcnt=0, IDLE). EX/MEM takes the bubble from EX. MEM/WB advances normally.
  - lu: ID/EX takes a bubble; EX/MEM and MEM/WB advance.
- stall = ext_stall | (BUSY & ~flush) | (lu & ~flush). stall is combinational and registers nothing.

## Timing
- Reset: all valid and control outputs 0, ex_rt=0, mcnt=0, state IDLE. stall=0 unless ext_stall; illegal follows its inputs.
- Decode-to-EX latency is 1 cycle; MEM is +1 and WB is +2 for non-stalled instructions.
- lu inserts exactly 1 bubble. The stalled instruction enters EX on the following edge.
- A mul stays in EX for MULT_LAT cycles and stall is high for MULT_LAT-1 cycles. MULT_LAT=1 never stalls.
- Back-to-back mul: the second mul loads the counter on the edge the first leaves EX.
- Reset asserted mid-multiply clears the sequencer on that edge; no stale controls remain after reset.

## Test plan
- Reset with opcode=001000, id_valid=1 -> all outputs 0 during rst. After release: ex_alu_op=110 and ex_alu_src=1 one cycle later; wb_rfile_w=1 three cycles after release.
- lw with rt=5 followed by R-type with rs=5 -> stall=1 for 1 cycle; EX shows a bubble (ex_valid=0), then the R-type with ex_alu_op=010.
- mul with MULT_LAT=3 -> stall high 2 cycles; ex_mult_sel=1 for 3 cycles; mem_valid=0 for 2 cycles, then mem_valid=1.
- flush asserted in the second BUSY cycle -> next edge ex_valid=0, stall=0, sequencer IDLE; no mul reaches MEM.
- ext_stall for 4 cycles with sw in EX -> all stage outputs frozen; mem_w=1 only after release, for 1 cycle.
- opcode=111111, id_valid=1 -> illegal=1; the next cycle is a bubble in EX with all controls 0.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// Bundle of decode inputs and per-stage control outputs between the datapath
// and ctrl_pipe_unit. The datapath side is master; the control unit is slave.
`timescale 1ns/1ps
interface ctrl_pipe_if;
  logic [5:0] opcode;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       flush;
  logic       ext_stall;

  logic       stall;
  logic       illegal;

  logic       ex_valid;
  logic       ex_rfile_dst;
  logic       ex_alu_src;
  logic       ex_mult_sel;
  logic [2:0] ex_alu_op;
  logic [4:0] ex_rt;

  logic       mem_valid;
  logic       mem_r;
  logic       mem_w;
  logic       mem_branch;

  logic       wb_valid;
  logic       wb_mem_to_rfile;
  logic       wb_rfile_w;

  modport master (
    output opcode, id_valid, id_rs, id_rt, flush, ext_stall,
    input  stall, illegal,
    input  ex_valid, ex_rfile_dst, ex_alu_src, ex_mult_sel, ex_alu_op, ex_rt,
    input  mem_valid, mem_r, mem_w, mem_branch,
    input  wb_valid, wb_mem_to_rfile, wb_rfile_w
  );

  modport slave (
    input  opcode, id_valid, id_rs, id_rt, flush, ext_stall,
    output stall, illegal,
    output ex_valid, ex_rfile_dst, ex_alu_src, ex_mult_sel, ex_alu_op, ex_rt,
    output mem_valid, mem_r, mem_w, mem_branch,
    output wb_valid, wb_mem_to_rfile, wb_rfile_w
  );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM and MEM/WB control registers,
// load-use and multi-cycle multiply stall, branch flush and external freeze.
`timescale 1ns/1ps
module ctrl_pipe_unit #(
  parameter int unsigned WIDTH_I  = 32,
  parameter int unsigned MULT_LAT = 3
) (
  input logic        clk,
  input logic        rst,
  ctrl_pipe_if.slave bus
);

  if (MULT_LAT < 1 || MULT_LAT > 16 || WIDTH_I < 6) begin : g_bad_param
    $error("ctrl_pipe_unit: MULT_LAT must be 1..16 and WIDTH_I at least 6");
  end

  typedef struct packed {
    logic       valid;
    logic       rfile_dst;
    logic       alu_src;
    logic       mem_to_rfile;
    logic       rfile_w;
    logic       mem_r;
    logic       mem_w;
    logic       branch;
    logic [2:0] alu_op;
    logic       mult_sel;
  } ex_ctl_t;

  typedef struct packed {
    logic valid;
    logic mem_r;
    logic mem_w;
    logic branch;
    logic mem_to_rfile;
    logic rfile_w;
  } mem_ctl_t;

  typedef struct packed {
    logic valid;
    logic mem_to_rfile;
    logic rfile_w;
  } wb_ctl_t;

  typedef enum logic {IDLE, BUSY} mstate_t;

  localparam logic [3:0] MCNT_LOAD = 4'(MULT_LAT - 1);

  ex_ctl_t    id_ctl, ex_q, ex_d;
  mem_ctl_t   mem_q, mem_d;
  wb_ctl_t    wb_q, wb_d;
  logic [4:0] ex_rt_q, ex_rt_d;
  logic [3:0] mcnt_q, mcnt_d;
  mstate_t    state_q, state_d;
  logic [10:0] dec;
  logic        defined;
  logic        lu;

  // dec order: rfile_dst, alu_src, mem_to_rfile, rfile_w, mem_r, mem_w, branch, alu_op, mult_sel
  always_comb begin
    dec     = '0;
    defined = 1'b1;
    case (bus.opcode)
      6'b000000: dec = 11'b1001000_010_0;
      6'b001000: dec = 11'b0101000_110_0;
      6'b001100: dec = 11'b0101000_111_0;
      6'b001101: dec = 11'b0101000_100_0;
      6'b100011: dec = 11'b0111100_000_0;
      6'b101011: dec = 11'b0100010_000_0;
      6'b000100: dec = 11'b0000001_001_0;
      6'b011100: dec = 11'b1001000_111_1;
      default:   defined = 1'b0;
    endcase
    id_ctl = (bus.id_valid && defined) ? {1'b1, dec} : '0;
  end

  assign bus.illegal = bus.id_valid & ~defined;

  assign lu = ex_q.valid & ex_q.mem_r & (ex_rt_q != 5'd0) & bus.id_valid &
              ((ex_rt_q == bus.id_rs) | (ex_rt_q == bus.id_rt));

  assign bus.stall = bus.ext_stall |
                     (~rst & ~bus.flush & ((state_q == BUSY) | lu));

  always_comb begin
    ex_d    = ex_q;
    ex_rt_d = ex_rt_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    mcnt_d  = mcnt_q;
    state_d = state_q;
    if (!bus.ext_stall) begin
      wb_d  = '{valid: mem_q.valid, mem_to_rfile: mem_q.mem_to_rfile,
                rfile_w: mem_q.rfile_w};
      mem_d = '{valid: ex_q.valid, mem_r: ex_q.mem_r, mem_w: ex_q.mem_w,
                branch: ex_q.branch, mem_to_rfile: ex_q.mem_to_rfile,
                rfile_w: ex_q.rfile_w};
      if (bus.flush) begin
        ex_d    = '0;
        ex_rt_d = '0;
        mem_d   = '0;
        mcnt_d  = '0;
        state_d = IDLE;
      end else if (state_q == BUSY) begin
        // mul holds in EX; leaving BUSY as the count reaches 0 lets it advance next edge
        mem_d = '0;
        if (mcnt_q <= 4'd1) begin
          mcnt_d  = '0;
          state_d = IDLE;
        end else begin
          mcnt_d = mcnt_q - 4'd1;
        end
      end else if (lu) begin
        ex_d    = '0;
        ex_rt_d = '0;
      end else begin
        ex_d    = id_ctl;
        ex_rt_d = id_ctl.valid ? bus.id_rt : '0;
        if (id_ctl.valid && id_ctl.mult_sel && MULT_LAT > 1) begin
          mcnt_d  = MCNT_LOAD;
          state_d = BUSY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      ex_rt_q <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      mcnt_q  <= '0;
      state_q <= IDLE;
    end else begin
      ex_q    <= ex_d;
      ex_rt_q <= ex_rt_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      mcnt_q  <= mcnt_d;
      state_q <= state_d;
    end
  end

  assign bus.ex_valid        = ex_q.valid;
  assign bus.ex_rfile_dst    = ex_q.rfile_dst;
  assign bus.ex_alu_src      = ex_q.alu_src;
  assign bus.ex_mult_sel     = ex_q.mult_sel;
  assign bus.ex_alu_op       = ex_q.alu_op;
  assign bus.ex_rt           = ex_rt_q;
  assign bus.mem_valid       = mem_q.valid;
  assign bus.mem_r           = mem_q.mem_r;
  assign bus.mem_w           = mem_q.mem_w;
  assign bus.mem_branch      = mem_q.branch;
  assign bus.wb_valid        = wb_q.valid;
  assign bus.wb_mem_to_rfile = wb_q.mem_to_rfile;
  assign bus.wb_rfile_w      = wb_q.rfile_w;

endmodule
